// File: rtl/combo_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : combo_lock_ctrl
// Description : Sequencing controller for the serial-code door lock.
//               Collects a CODE_LEN-bit code one bit per bit_valid strobe
//               (MSB first), compares it against the programmable code,
//               opens the lock for a timed window on a match, counts
//               consecutive wrong entries and enforces a timed lockout once
//               MAX_FAIL wrong entries have been seen in a row.
//
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous, active-high reset
//               bit_valid  - bit_in is presented this cycle
//               bit_in     - serial code bit, MSB of the code first
//               code       - expected code, sampled on the final-bit cycle
//               relock     - force lock closed / abort a partial entry
//               unlock     - lock open (registered)
//               locked_out - lockout active (registered)
//               fail_pulse - one-cycle pulse per wrong entry (registered)
//               fail_cnt   - consecutive failure count (registered)
//
// Revision    : 1.0 - initial release
// ============================================================================
module combo_lock_ctrl #(
    parameter int CODE_LEN       = 4,
    parameter int UNLOCK_CYCLES  = 8,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              bit_valid,
    input  logic                              bit_in,
    input  logic [CODE_LEN-1:0]               code,
    input  logic                              relock,
    output logic                              unlock,
    output logic                              locked_out,
    output logic                              fail_pulse,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W  = $clog2(CODE_LEN);
    localparam int c_FAIL_W = $clog2(MAX_FAIL + 1);
    // Only CODE_LEN-1 history bits are needed: the final bit is taken
    // straight from bit_in on the compare cycle.
    localparam int c_SHR_W  = CODE_LEN - 1;
    // One timer serves both the unlock window and the lockout window.
    localparam int c_TMAX   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                               : LOCKOUT_CYCLES;
    localparam int c_TMR_W  = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    localparam logic [c_CNT_W-1:0]  c_LAST_BIT     = c_CNT_W'(CODE_LEN - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [c_TMR_W-1:0]  c_UNLOCK_LOAD  = c_TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]  c_LOCKOUT_LOAD = c_TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]  c_TMR_ONE      = c_TMR_W'(1);
    localparam logic [c_FAIL_W-1:0] c_FAIL_MAX     = c_FAIL_W'(MAX_FAIL);
    localparam logic [c_FAIL_W-1:0] c_FAIL_ONE     = c_FAIL_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_COLLECT = 2'd0;
    localparam logic [1:0] c_ST_OPEN    = 2'd1;
    localparam logic [1:0] c_ST_LOCKOUT = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [c_SHR_W-1:0]  r_shreg;
    logic [c_TMR_W-1:0]  r_timer;
    logic [c_FAIL_W-1:0] r_fail_cnt;
    logic                r_unlock;
    logic                r_locked_out;
    logic                r_fail_pulse;

    // ------------------------------------------------------------------------
    // Next-state / datapath wires
    // ------------------------------------------------------------------------
    logic [1:0]          w_state_next;
    logic [c_CNT_W-1:0]  w_bit_cnt_next;
    logic [c_SHR_W-1:0]  w_shreg_next;
    logic [c_TMR_W-1:0]  w_timer_next;
    logic [c_FAIL_W-1:0] w_fail_cnt_next;
    logic                w_unlock_next;
    logic                w_locked_out_next;
    logic                w_fail_pulse_next;

    logic [CODE_LEN-1:0] w_code_word;   // history plus the bit on the wire
    logic [c_FAIL_W-1:0] w_fail_inc;
    logic                w_entry_done;  // final bit accepted this cycle
    logic                w_code_match;

    assign w_code_word  = {r_shreg, bit_in};
    assign w_fail_inc   = r_fail_cnt + c_FAIL_ONE;
    assign w_code_match = (w_code_word == code);

    // ------------------------------------------------------------------------
    // Process 1: state and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_COLLECT;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_timer      <= '0;
            r_fail_cnt   <= '0;
            r_unlock     <= 1'b0;
            r_locked_out <= 1'b0;
            r_fail_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_shreg      <= w_shreg_next;
            r_timer      <= w_timer_next;
            r_fail_cnt   <= w_fail_cnt_next;
            r_unlock     <= w_unlock_next;
            r_locked_out <= w_locked_out_next;
            r_fail_pulse <= w_fail_pulse_next;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_shreg_next    = r_shreg;
        w_timer_next    = r_timer;
        w_fail_cnt_next = r_fail_cnt;
        w_entry_done    = 1'b0;

        case (r_state)
            c_ST_COLLECT: begin
                if (relock) begin
                    // Abort the partial entry; a strobe in the same cycle
                    // is dropped so the next entry starts clean.
                    w_bit_cnt_next = '0;
                end else if (bit_valid) begin
                    w_shreg_next = w_code_word[c_SHR_W-1:0];
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_entry_done   = 1'b1;
                        w_bit_cnt_next = '0;
                        if (w_code_match) begin
                            w_state_next    = c_ST_OPEN;
                            w_timer_next    = c_UNLOCK_LOAD;
                            w_fail_cnt_next = '0;
                        end else if (w_fail_inc == c_FAIL_MAX) begin
                            w_state_next    = c_ST_LOCKOUT;
                            w_timer_next    = c_LOCKOUT_LOAD;
                            w_fail_cnt_next = c_FAIL_MAX;
                        end else begin
                            w_fail_cnt_next = w_fail_inc;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + c_CNT_ONE;
                    end
                end
            end

            c_ST_OPEN: begin
                // Timer runs UNLOCK_CYCLES-1 down to 0, one cycle each, so
                // the window spans exactly UNLOCK_CYCLES cycles.
                if (relock || (r_timer == '0)) begin
                    w_state_next = c_ST_COLLECT;
                end else begin
                    w_timer_next = r_timer - c_TMR_ONE;
                end
            end

            c_ST_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_state_next    = c_ST_COLLECT;
                    w_fail_cnt_next = '0;
                    w_bit_cnt_next  = '0;
                end else begin
                    w_timer_next = r_timer - c_TMR_ONE;
                end
            end

            default: begin
                w_state_next   = c_ST_COLLECT;
                w_bit_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: output decode (registered in process 1)
    // ------------------------------------------------------------------------
    // Outputs are decoded from the next state so the registered copies line
    // up with the state register: unlock rises the cycle after the final bit
    // and the two window flags are mutually exclusive by construction.
    always_comb begin
        w_unlock_next     = 1'b0;
        w_locked_out_next = 1'b0;
        w_fail_pulse_next = 1'b0;

        if (w_state_next == c_ST_OPEN) begin
            w_unlock_next = 1'b1;
        end
        if (w_state_next == c_ST_LOCKOUT) begin
            w_locked_out_next = 1'b1;
        end
        if (w_entry_done && !w_code_match) begin
            w_fail_pulse_next = 1'b1;
        end
    end

    assign unlock     = r_unlock;
    assign locked_out = r_locked_out;
    assign fail_pulse = r_fail_pulse;
    assign fail_cnt   = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_combo_lock_ctrl
// Description : Self-checking bench for combo_lock_ctrl (default parameters,
//               code = 4'b1011). Table of per-cycle vectors followed by
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_combo_lock_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_valid;
    logic       bit_in;
    logic [3:0] code;
    logic       relock;
    logic       unlock;
    logic       locked_out;
    logic       fail_pulse;
    logic [1:0] fail_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      nm;
        logic       rst;
        logic       v;
        logic       b;
        logic       rl;
        logic       eu;
        logic       el;
        logic       ef;
        logic [1:0] ec;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    combo_lock_ctrl #(
        .CODE_LEN       (4),
        .UNLOCK_CYCLES  (8),
        .MAX_FAIL       (3),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .code       (code),
        .relock     (relock),
        .unlock     (unlock),
        .locked_out (locked_out),
        .fail_pulse (fail_pulse),
        .fail_cnt   (fail_cnt)
    );

    task automatic add(input string nm, input logic r, input logic v,
                       input logic b, input logic rl, input logic eu,
                       input logic el, input logic ef, input logic [1:0] ec);
        vec_t e;
        e.nm = nm; e.rst = r; e.v = v; e.b = b; e.rl = rl;
        e.eu = eu; e.el = el; e.ef = ef; e.ec = ec;
        vq.push_back(e);
    endtask

    task automatic add_idle(input string nm, input int n, input logic eu,
                            input logic el, input logic [1:0] ec);
        for (int i = 0; i < n; i++) add(nm, 0, 0, 0, 0, eu, el, 0, ec);
    endtask

    task automatic check(input string nm, input logic eu, input logic el,
                         input logic ef, input logic [1:0] ec);
        total++;
        if ({unlock, locked_out, fail_pulse, fail_cnt} !== {eu, el, ef, ec}) begin
            bad++;
            $display("FAIL %s: got unlock=%b locked_out=%b fail_pulse=%b fail_cnt=%0d, want unlock=%b locked_out=%b fail_pulse=%b fail_cnt=%0d",
                     nm, unlock, locked_out, fail_pulse, fail_cnt, eu, el, ef, ec);
        end
        total++;
        if ((unlock === 1'b1) && ((locked_out === 1'b1) || (fail_pulse === 1'b1))) begin
            bad++;
            $display("FAIL %s_overlap: got unlock=%b locked_out=%b fail_pulse=%b, want no flag alongside unlock",
                     nm, unlock, locked_out, fail_pulse);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
    task automatic step(input logic r, input logic v, input logic b, input logic rl);
        reset = r; bit_valid = v; bit_in = b; relock = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic sc(input string nm, input logic r, input logic v,
                      input logic b, input logic rl, input logic eu,
                      input logic el, input logic ef, input logic [1:0] ec);
        step(r, v, b, rl);
        check(nm, eu, el, ef, ec);
    endtask

    // Four back-to-back bits, MSB first; only the last one produces a result.
    task automatic enter(input string nm, input logic [3:0] bits,
                         input logic [1:0] cnt_before, input logic eu,
                         input logic el, input logic ef, input logic [1:0] ec);
        for (int i = 3; i >= 1; i--) sc(nm, 0, 1, bits[i], 0, 0, 0, 0, cnt_before);
        sc(nm, 0, 1, bits[0], 0, eu, el, ef, ec);
    endtask

    initial begin
        reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; relock = 1'b0;
        code  = 4'b1011;

        // ---- correct entry -------------------------------------------------
        add("rst",      1, 0, 0, 0, 0, 0, 0, 0);
        add("rst",      1, 0, 0, 0, 0, 0, 0, 0);
        add("ok_b3",    0, 1, 1, 0, 0, 0, 0, 0);
        add("ok_b2",    0, 1, 0, 0, 0, 0, 0, 0);
        add("ok_b1",    0, 1, 1, 0, 0, 0, 0, 0);
        add("ok_b0",    0, 1, 1, 0, 1, 0, 0, 0);
        add_idle("open_hold", 7, 1, 0, 0);
        add_idle("open_end",  1, 0, 0, 0);

        // ---- wrong entry then gapped correct entry ---------------------------
        add("bad_b3",   0, 1, 1, 0, 0, 0, 0, 0);
        add("bad_b2",   0, 1, 0, 0, 0, 0, 0, 0);
        add("bad_b1",   0, 1, 0, 0, 0, 0, 0, 0);
        add("bad_b0",   0, 1, 1, 0, 0, 0, 1, 1);
        add_idle("bad_after", 1, 0, 0, 1);
        add("gap_b3",   0, 1, 1, 0, 0, 0, 0, 1);
        add_idle("gap",       2, 0, 0, 1);
        add("gap_b2",   0, 1, 0, 0, 0, 0, 0, 1);
        add_idle("gap",       2, 0, 0, 1);
        add("gap_b1",   0, 1, 1, 0, 0, 0, 0, 1);
        add_idle("gap",       2, 0, 0, 1);
        add("gap_b0",   0, 1, 1, 0, 1, 0, 0, 0);
        add_idle("gap_open",  7, 1, 0, 0);
        add_idle("gap_close", 1, 0, 0, 0);

        // ---- three wrong entries -> lockout ----------------------------------
        for (int k = 1; k <= 12; k++) begin
            case (k)
                4:       add("lk_fail1", 0, 1, 0, 0, 0, 0, 1, 1);
                8:       add("lk_fail2", 0, 1, 0, 0, 0, 0, 1, 2);
                12:      add("lk_fail3", 0, 1, 0, 0, 0, 1, 1, 3);
                default: add("lk_bits",  0, 1, 0, 0, 0, 0, 0, (k < 4) ? 2'd0 : (k < 8) ? 2'd1 : 2'd2);
            endcase
        end
        // Correct code and a relock during lockout must be ignored.
        add("lk_try_b3", 0, 1, 1, 0, 0, 1, 0, 3);
        add("lk_try_b2", 0, 1, 0, 0, 0, 1, 0, 3);
        add("lk_try_b1", 0, 1, 1, 1, 0, 1, 0, 3);
        add("lk_try_b0", 0, 1, 1, 0, 0, 1, 0, 3);
        add_idle("lk_hold",   11, 0, 1, 3);
        add_idle("lk_expire", 1,  0, 0, 0);
        add("post_b3",  0, 1, 1, 0, 0, 0, 0, 0);
        add("post_b2",  0, 1, 0, 0, 0, 0, 0, 0);
        add("post_b1",  0, 1, 1, 0, 0, 0, 0, 0);
        add("post_b0",  0, 1, 1, 0, 1, 0, 0, 0);
        add("post_rl",  0, 0, 0, 1, 0, 0, 0, 0);

        foreach (vq[i]) sc(vq[i].nm, vq[i].rst, vq[i].v, vq[i].b, vq[i].rl,
                           vq[i].eu, vq[i].el, vq[i].ef, vq[i].ec);

        // ---- relock in the 3rd cycle of OPEN ---------------------------------
        enter("open_entry", 4'b1011, 0, 1, 0, 0, 0);
        sc("open_c2",      0, 0, 0, 0, 1, 0, 0, 0);
        sc("open_relock",  0, 0, 0, 1, 0, 0, 0, 0);
        sc("open_closed",  0, 0, 0, 0, 0, 0, 0, 0);

        // ---- relock discards a partial entry ---------------------------------
        sc("part_b1",      0, 1, 1, 0, 0, 0, 0, 0);
        sc("part_b0",      0, 1, 0, 0, 0, 0, 0, 0);
        sc("part_relock",  0, 1, 1, 1, 0, 0, 0, 0);
        sc("part_n1",      0, 1, 1, 0, 0, 0, 0, 0);
        sc("part_n2",      0, 1, 1, 0, 0, 0, 0, 0);
        sc("part_relock2", 0, 0, 0, 1, 0, 0, 0, 0);
        enter("part_full", 4'b1011, 0, 1, 0, 0, 0);
        sc("part_close",   0, 0, 0, 1, 0, 0, 0, 0);

        // ---- reset during OPEN -----------------------------------------------
        enter("ro_entry",  4'b1011, 0, 1, 0, 0, 0);
        sc("ro_reset",     1, 0, 0, 0, 0, 0, 0, 0);
        sc("ro_idle",      0, 0, 0, 0, 0, 0, 0, 0);
        enter("ro_fresh",  4'b1011, 0, 1, 0, 0, 0);
        sc("ro_close",     0, 0, 0, 1, 0, 0, 0, 0);

        // ---- reset during LOCKOUT --------------------------------------------
        enter("rl_f1",     4'b0000, 0, 0, 0, 1, 1);
        enter("rl_f2",     4'b0000, 1, 0, 0, 1, 2);
        enter("rl_f3",     4'b0000, 2, 0, 1, 1, 3);
        sc("rl_hold",      0, 0, 0, 0, 0, 1, 0, 3);
        sc("rl_reset",     1, 0, 0, 0, 0, 0, 0, 0);
        enter("rl_fresh",  4'b1011, 0, 1, 0, 0, 0);
        sc("rl_close",     0, 0, 0, 1, 0, 0, 0, 0);

        // ---- reset after 2 bits of an entry ----------------------------------
        enter("rm_fail",   4'b0000, 0, 0, 0, 1, 1);
        sc("rm_b1",        0, 1, 1, 0, 0, 0, 0, 1);
        sc("rm_b0",        0, 1, 0, 0, 0, 0, 0, 1);
        sc("rm_reset",     1, 0, 0, 0, 0, 0, 0, 0);
        enter("rm_fresh",  4'b1011, 0, 1, 0, 0, 0);
        sc("rm_close",     0, 0, 0, 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
